// File: rtl/gemv_tile_engine.sv
// gemv_tile_engine: accumulates any number of ROWS x COLS weight tiles into one
// ROWS-wide GEMV result block, with optional bias preload and fixed-point
// requantisation, behind valid/ready handshakes on both sides.
// Optional feature macro: MAC_ARRAY_SAT_EN. When defined, results are clipped
// to the signed DATA_W range and out_sat flags clipped rows. When undefined,
// results wrap to DATA_W bits and out_sat stays 0.
//
// state    | meaning
// ST_IDLE  | waiting for the first tile of a vector (accumulator preload)
// ST_ACCUM | accepting further tiles, one per cycle
// ST_DRAIN | last tile still travelling through the MAC pipeline
// ST_OUT   | result block held until the consumer takes it
module gemv_tile_engine #(
  parameter int DATA_W    = 16,
  parameter int ROWS      = 16,
  parameter int COLS      = 16,
  parameter int ACC_W     = 40,
  parameter int FRAC_BITS = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic                          mode,
  input  logic [ROWS*COLS*DATA_W-1:0]   w_in,
  input  logic [COLS*DATA_W-1:0]        x_in,
  input  logic [ROWS*DATA_W-1:0]        bias_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ROWS*DATA_W-1:0]        out_data,
  output logic [ROWS-1:0]               out_sat,
  output logic [15:0]                   tile_cnt
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(COLS);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC_BITS - 1);
`ifdef MAC_ARRAY_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DRAIN, ST_OUT} state_t;

  state_t                    state, state_nxt;
  logic [1:0]                drain_cnt;
  logic                      in_hs, out_hs, load_out;
  logic                      s1_valid, s2_valid;
  logic signed [PROD_W-1:0]  prod_d  [ROWS][COLS];
  logic signed [PROD_W-1:0]  s1_prod [ROWS][COLS];
  logic signed [SUM_W-1:0]   sum_d   [ROWS];
  logic signed [SUM_W-1:0]   s2_sum  [ROWS];
  logic signed [ACC_W-1:0]   acc     [ROWS];
  logic signed [ACC_W-1:0]   rnd     [ROWS];
`ifdef MAC_ARRAY_SAT_EN
  logic signed [ACC_W-1:0]   t_val   [ROWS];
`endif
  logic [ROWS*DATA_W-1:0]    q_data;
  logic [ROWS-1:0]           q_sat;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state, handshake strobes and flow-control outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = in_last ? ST_DRAIN : ST_ACCUM;
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt == 2'd0) state_nxt = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    in_hs    = in_valid & in_ready;
    out_hs   = out_valid & out_ready;
    load_out = (state == ST_DRAIN) && (drain_cnt == 2'd0);
  end

  // Drain timer: covers the last tile's trip through S1, S2 and S3 before requantising.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      drain_cnt <= 2'd0;
    else if (in_hs && in_last)                       drain_cnt <= 2'd2;
    else if (state == ST_DRAIN && drain_cnt != 2'd0) drain_cnt <= drain_cnt - 2'd1;
  end

  // Tile counter, saturating, cleared when the result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          tile_cnt <= 16'd0;
    else if (out_hs)                     tile_cnt <= 16'd0;
    else if (in_hs && tile_cnt != 16'hFFFF) tile_cnt <= tile_cnt + 16'd1;
  end

  // Element products of the incoming tile and per-row sums of the S1 products.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      sum_d[r] = '0;
      for (int c = 0; c < COLS; c++) begin
        prod_d[r][c] = PROD_W'($signed(w_in[(r*COLS+c)*DATA_W +: DATA_W]))
                     * PROD_W'($signed(x_in[c*DATA_W +: DATA_W]));
        sum_d[r]     = sum_d[r] + SUM_W'(s1_prod[r][c]);
      end
    end
  end

  // S1/S2 pipeline registers; products only load on an accepted tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        s2_sum[r] <= '0;
        for (int c = 0; c < COLS; c++) s1_prod[r][c] <= '0;
      end
    end else begin
      s1_valid <= in_hs;
      s2_valid <= s1_valid;
      for (int r = 0; r < ROWS; r++) begin
        s2_sum[r] <= sum_d[r];
        if (in_hs) begin
          for (int c = 0; c < COLS; c++) s1_prod[r][c] <= prod_d[r][c];
        end
      end
    end
  end

  // S3 accumulator: bias preload on the first tile, wrap-around accumulation after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) acc[r] <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (out_hs)
          acc[r] <= '0;
        else if (in_hs && state == ST_IDLE)
          acc[r] <= mode ? (ACC_W'($signed(bias_in[r*DATA_W +: DATA_W])) <<< FRAC_BITS) : '0;
        else if (s2_valid)
          acc[r] <= acc[r] + ACC_W'(s2_sum[r]);
      end
    end
  end

  // Requantisation: round half up, arithmetic shift, then clip or wrap.
  always_comb begin
    q_data = '0;
    q_sat  = '0;
    for (int r = 0; r < ROWS; r++) begin
      rnd[r] = acc[r] + HALF;
`ifdef MAC_ARRAY_SAT_EN
      t_val[r] = rnd[r] >>> FRAC_BITS;
      if (t_val[r] > MAX_V) begin
        q_data[r*DATA_W +: DATA_W] = MAX_V[DATA_W-1:0];
        q_sat[r]                   = 1'b1;
      end else if (t_val[r] < MIN_V) begin
        q_data[r*DATA_W +: DATA_W] = MIN_V[DATA_W-1:0];
        q_sat[r]                   = 1'b1;
      end else begin
        q_data[r*DATA_W +: DATA_W] = t_val[r][DATA_W-1:0];
      end
`else
      q_data[r*DATA_W +: DATA_W] = DATA_W'(rnd[r] >>> FRAC_BITS);
`endif
    end
  end

  // Result registers, loaded when the drain completes and held through OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sat  <= '0;
    end else if (load_out) begin
      out_data <= q_data;
      out_sat  <= q_sat;
    end
  end

endmodule

// File: tb/tb_gemv_tile_engine.sv
// Testbench for gemv_tile_engine with ROWS=COLS=4, DATA_W=16, FRAC_BITS=8.
// Reference model keeps a per-row 64-bit accumulator built from the plain
// GEMV arithmetic and applies the rounding / clip-or-wrap rule at the end.
module tb_gemv_tile_engine;
  localparam int DW = 16;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int AW = 40;
  localparam int FB = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_last = 1'b0;
  logic              mode = 1'b0;
  logic [R*C*DW-1:0] w_in = '0;
  logic [C*DW-1:0]   x_in = '0;
  logic [R*DW-1:0]   bias_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [R*DW-1:0]   out_data;
  logic [R-1:0]      out_sat;
  logic [15:0]       tile_cnt;

  gemv_tile_engine #(.DATA_W(DW), .ROWS(R), .COLS(C), .ACC_W(AW), .FRAC_BITS(FB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .mode(mode), .w_in(w_in), .x_in(x_in), .bias_in(bias_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .tile_cnt(tile_cnt)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_pass   = 0;
  int     tw [R][C];
  int     tx [C];
  int     tbias [R];
  longint ref_acc [R];
  int     ref_tiles = 0;
  logic [R*DW-1:0] exp_d;
  logic [R-1:0]    exp_s;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd_val(input int amp);
    return int'($urandom_range(2 * amp)) - amp;
  endfunction

  task automatic rand_tile(input int amp);
    for (int r = 0; r < R; r++) begin
      tbias[r] = rnd_val(amp);
      for (int c = 0; c < C; c++) tw[r][c] = rnd_val(amp);
    end
    for (int c = 0; c < C; c++) tx[c] = rnd_val(amp);
  endtask

  task automatic fill_tile(input int wv, input int xv, input int bv);
    for (int r = 0; r < R; r++) begin
      tbias[r] = bv;
      for (int c = 0; c < C; c++) tw[r][c] = wv;
    end
    for (int c = 0; c < C; c++) tx[c] = xv;
  endtask

  // Offers the current tile until accepted; updates the reference accumulators.
  task automatic send_tile(input bit m, input bit first, input bit last, output int waited);
    waited = 0;
    for (int r = 0; r < R; r++) begin
      bias_in[r*DW +: DW] = tbias[r][DW-1:0];
      for (int c = 0; c < C; c++) w_in[(r*C+c)*DW +: DW] = tw[r][c][DW-1:0];
    end
    for (int c = 0; c < C; c++) x_in[c*DW +: DW] = tx[c][DW-1:0];
    mode = m; in_last = last; in_valid = 1'b1;
    while (in_ready !== 1'b1 && waited < 20) begin step(); waited++; end
    if (in_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL tile_accept: in_ready=%b after %0d cycles, want 1", in_ready, waited);
      in_valid = 1'b0; in_last = 1'b0; waited = -1;
      return;
    end
    step();
    in_valid = 1'b0; in_last = 1'b0;
    for (int r = 0; r < R; r++) begin
      if (first) ref_acc[r] = m ? longint'(tbias[r]) * (longint'(1) << FB) : 64'sd0;
      for (int c = 0; c < C; c++) ref_acc[r] += longint'(tw[r][c]) * longint'(tx[c]);
    end
    ref_tiles = first ? 1 : ref_tiles + 1;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin step(); cyc++; end
    if (out_valid !== 1'b1) begin
      n_checks++;
      $display("FAIL out_timeout: out_valid=%b after %0d cycles, want 1", out_valid, cyc);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // Expected result: floor((acc + 128) / 256), then clip or wrap to 16 bits.
  task automatic ref_out();
    longint t;
    for (int r = 0; r < R; r++) begin
      t = (ref_acc[r] + 128) >>> FB;
`ifdef MAC_ARRAY_SAT_EN
      if (t > 32767) begin
        exp_d[r*DW +: DW] = 16'h7FFF; exp_s[r] = 1'b1;
      end else if (t < -32768) begin
        exp_d[r*DW +: DW] = 16'h8000; exp_s[r] = 1'b1;
      end else begin
        exp_d[r*DW +: DW] = t[DW-1:0]; exp_s[r] = 1'b0;
      end
`else
      exp_d[r*DW +: DW] = t[DW-1:0];
      exp_s[r] = 1'b0;
`endif
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== '0) $display("FAIL rst_out_data: got %h want 0", out_data); else n_pass++;
    n_checks++; if (out_sat !== '0) $display("FAIL rst_out_sat: got %b want 0", out_sat); else n_pass++;
    n_checks++; if (tile_cnt !== 16'd0) $display("FAIL rst_tile_cnt: got %0d want 0", tile_cnt); else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_tile();
    int w;
    fill_tile(0, 0, 0);
    for (int i = 0; i < R; i++) tw[i][i] = 256;
    tx[0] = 256; tx[1] = 512; tx[2] = -256; tx[3] = 0;
    send_tile(1'b0, 1'b1, 1'b1, w);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL single_ready_n: got %b want 0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_valid_n: got %b want 0", out_valid); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_valid_n1: got %b want 0", out_valid); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_valid_n2: got %b want 0", out_valid); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid_n3: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== {16'h0000, 16'hFF00, 16'h0200, 16'h0100})
      $display("FAIL single_data: got %h want 0000ff0002000100", out_data); else n_pass++;
    n_checks++; if (out_sat !== 4'b0000) $display("FAIL single_sat: got %b want 0000", out_sat); else n_pass++;
    n_checks++; if (tile_cnt !== 16'd1) $display("FAIL single_tile_cnt: got %0d want 1", tile_cnt); else n_pass++;
    release_out();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || tile_cnt !== 16'd0)
      $display("FAIL single_post_hs: valid=%b ready=%b cnt=%0d want 0/1/0", out_valid, in_ready, tile_cnt);
    else n_pass++;
  endtask

  task automatic test_multi_bias();
    int w0, w1, w2, cyc;
    bit bad;
    fill_tile(256, 256, 128);
    send_tile(1'b1, 1'b1, 1'b0, w0);
    fill_tile(256, 256, 999);
    send_tile(1'b0, 1'b0, 1'b0, w1);
    send_tile(1'b0, 1'b0, 1'b1, w2);
    n_checks++; if (w1 !== 0 || w2 !== 0) $display("FAIL multi_throughput: waits %0d/%0d want 0/0", w1, w2); else n_pass++;
    cyc = 0; bad = 1'b0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      if (in_ready !== 1'b0) bad = 1'b1;
      step(); cyc++;
    end
    n_checks++; if (bad) $display("FAIL multi_drain_ready: in_ready high during drain, want 0"); else n_pass++;
    n_checks++; if (cyc !== 3) $display("FAIL multi_latency: got %0d cycles want 3", cyc); else n_pass++;
    n_checks++; if (out_data !== {4{16'd3200}}) $display("FAIL multi_data: got %h want %h", out_data, {4{16'd3200}}); else n_pass++;
    n_checks++; if (tile_cnt !== 16'd3) $display("FAIL multi_tile_cnt: got %0d want 3", tile_cnt); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL multi_out_ready_n: got %b want 0", in_ready); else n_pass++;
    release_out();
  endtask

  task automatic test_backpressure();
    int w, cyc;
    logic [R*DW-1:0] held;
    rand_tile(300);
    send_tile(1'b1, 1'b1, 1'b1, w);
    wait_out(cyc);
    ref_out();
    held = out_data;
    n_checks++; if (out_data !== exp_d) $display("FAIL bp_data: got %h want %h", out_data, exp_d); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid_hold: got %b want 1", out_valid); else n_pass++;
      n_checks++; if (out_data !== held) $display("FAIL bp_data_hold: got %h want %h", out_data, held); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready); else n_pass++;
    end
    release_out();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release: ready=%b valid=%b want 1/0", in_ready, out_valid); else n_pass++;
    rand_tile(300);
    send_tile(1'b0, 1'b1, 1'b1, w);
    n_checks++; if (w !== 0) $display("FAIL bp_next_accept: waited %0d want 0", w); else n_pass++;
    wait_out(cyc);
    ref_out();
    n_checks++; if (out_data !== exp_d) $display("FAIL bp_next_data: got %h want %h", out_data, exp_d); else n_pass++;
    release_out();
  endtask

  task automatic test_saturation();
    int w, cyc;
    fill_tile(32767, 32767, 0);
    for (int i = 0; i < 4; i++) send_tile(1'b0, i == 0, i == 3, w);
    wait_out(cyc);
`ifdef MAC_ARRAY_SAT_EN
    n_checks++; if (out_data !== {4{16'h7FFF}}) $display("FAIL sat_data: got %h want %h", out_data, {4{16'h7FFF}}); else n_pass++;
    n_checks++; if (out_sat !== 4'b1111) $display("FAIL sat_flags: got %b want 1111", out_sat); else n_pass++;
`else
    n_checks++; if (out_data !== {4{16'hF000}}) $display("FAIL wrap_data: got %h want %h", out_data, {4{16'hF000}}); else n_pass++;
    n_checks++; if (out_sat !== 4'b0000) $display("FAIL wrap_flags: got %b want 0000", out_sat); else n_pass++;
`endif
    n_checks++; if (tile_cnt !== 16'd4) $display("FAIL sat_tile_cnt: got %0d want 4", tile_cnt); else n_pass++;
    release_out();
  endtask

  task automatic test_rounding();
    int w, cyc;
    fill_tile(0, 0, 0);
    tx[0] = 1; tx[1] = 256;
    tw[0][0] = -384;   // acc -384   -> -1.5 -> -1
    tw[1][0] = 384;    // acc 384    -> 1.5  -> 2
    tw[2][1] = 384;    // acc 98304  -> 384
    tw[3][0] = -128;   // acc -128   -> -0.5 -> 0
    send_tile(1'b0, 1'b1, 1'b1, w);
    wait_out(cyc);
    n_checks++; if (out_data !== {16'h0000, 16'h0180, 16'h0002, 16'hFFFF})
      $display("FAIL round_data: got %h want 000001800002ffff", out_data); else n_pass++;
    n_checks++; if (out_sat !== 4'b0000) $display("FAIL round_sat: got %b want 0000", out_sat); else n_pass++;
    release_out();
  endtask

  task automatic test_reset_abort();
    int w, cyc;
    rand_tile(32767);
    send_tile(1'b1, 1'b1, 1'b0, w);
    rand_tile(32767);
    send_tile(1'b0, 1'b0, 1'b0, w);
    n_checks++; if (tile_cnt !== 16'd2) $display("FAIL abort_pre_cnt: got %0d want 2", tile_cnt); else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (tile_cnt !== 16'd0) $display("FAIL abort_cnt: got %0d want 0", tile_cnt); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", in_ready); else n_pass++;
    step(); step();
    rst_n = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL abort_no_result: out_valid=%b want 0", out_valid); else n_pass++;
    rand_tile(200);
    send_tile(1'b0, 1'b1, 1'b0, w);
    rand_tile(200);
    send_tile(1'b1, 1'b0, 1'b1, w);
    wait_out(cyc);
    ref_out();
    n_checks++; if (out_data !== exp_d) $display("FAIL abort_next_data: got %h want %h", out_data, exp_d); else n_pass++;
    n_checks++; if (tile_cnt !== 16'd2) $display("FAIL abort_next_cnt: got %0d want 2", tile_cnt); else n_pass++;
    release_out();
  endtask

  task automatic test_random();
    int w, cyc, nt, amp, dly;
    bit m;
    for (int v = 0; v < 8; v++) begin
      nt  = int'($urandom_range(1, 5));
      amp = ($urandom_range(1) == 0) ? 200 : 32767;
      m   = 1'($urandom_range(1));
      for (int t = 0; t < nt; t++) begin
        repeat ($urandom_range(2)) step();
        rand_tile(amp);
        send_tile(t == 0 ? m : 1'($urandom_range(1)), t == 0, t == nt - 1, w);
      end
      wait_out(cyc);
      ref_out();
      dly = int'($urandom_range(3));
      repeat (dly) step();
      n_checks++; if (out_data !== exp_d) $display("FAIL rand_data[%0d]: got %h want %h", v, out_data, exp_d); else n_pass++;
      n_checks++; if (out_sat !== exp_s) $display("FAIL rand_sat[%0d]: got %b want %b", v, out_sat, exp_s); else n_pass++;
      n_checks++; if (tile_cnt !== 16'(ref_tiles)) $display("FAIL rand_cnt[%0d]: got %0d want %0d", v, tile_cnt, ref_tiles); else n_pass++;
      release_out();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_tile();
    test_multi_bias();
    test_backpressure();
    test_saturation();
    test_rounding();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
